// File: rtl/uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO.
// A push is accepted when full only if a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign data_o  = mem[rd_ptr];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and combinational status read.
// Optional UART_TX_IRQ_EN adds a CTRL register and a registered idle interrupt irq_o.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hF000_0000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] data_in_i,
  output logic [31:0] data_out_o,
  output logic        sel_o,
`ifdef UART_TX_IRQ_EN
  output logic        irq_o,
`endif
  output logic        tx_o
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  uart_tx_state_t state, state_n;
  logic [BW-1:0]  baud_cnt, baud_n;
  logic [2:0]     bit_idx, bit_n;
  logic [7:0]     shift_r, shift_n;

  logic          wr_tx, wr_st, wr_q, st_q, push_edge, st_edge;
  logic          pop, overflow;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_data;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status;
  logic          unused_bits;

  assign sel_o = (addr_i[31:4] == BASE_ADDR[31:4]);
  assign wr_tx = sel_o & we_i & (addr_i[3:2] == REG_TXDATA);
  assign wr_st = sel_o & we_i & (addr_i[3:2] == REG_STATUS);

  // The core holds we_i for two cycles per store, so only the rising edge acts.
  assign push_edge = wr_tx & ~wr_q;
  assign st_edge   = wr_st & ~st_q;
  assign unused_bits = ^{addr_i[1:0], data_in_i[31:8]};

  always_ff @(posedge clk) begin
    if (reset_i) begin
      wr_q     <= 1'b0;
      st_q     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_q <= wr_tx;
      st_q <= wr_st;
      if (push_edge & fifo_full & ~pop)        overflow <= 1'b1;
      else if (st_edge & data_in_i[ST_OVF])   overflow <= 1'b0;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_i (reset_i),
    .push_i  (push_edge),
    .pop_i   (pop),
    .data_i  (data_in_i[7:0]),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_r  <= '0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      shift_r  <= shift_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    shift_n = shift_r;
    pop     = 1'b0;
    tx_o    = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_data;
          baud_n  = BAUD_MAX;
          state_n = START;
        end
      end
      START: begin
        tx_o = 1'b0;
        if (baud_cnt == '0) begin
          state_n = DATA;
          bit_n   = 3'd0;
          baud_n  = BAUD_MAX;
        end else begin
          baud_n = baud_cnt - BW'(1);
        end
      end
      DATA: begin
        tx_o = shift_r[0];
        if (baud_cnt == '0) begin
          shift_n = {1'b0, shift_r[7:1]};
          baud_n  = BAUD_MAX;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end else begin
          baud_n = baud_cnt - BW'(1);
        end
      end
      STOP: begin
        if (baud_cnt == '0) state_n = IDLE;
        else                baud_n  = baud_cnt - BW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef UART_TX_IRQ_EN
  logic wr_ct, ct_q, irq_en, irq_r;

  assign wr_ct = sel_o & we_i & (addr_i[3:2] == REG_CTRL);
  assign irq_o = irq_r;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      ct_q   <= 1'b0;
      irq_en <= 1'b0;
      irq_r  <= 1'b0;
    end else begin
      ct_q <= wr_ct;
      if (wr_ct & ~ct_q) irq_en <= data_in_i[0];
      irq_r <= irq_en & fifo_empty & (state == IDLE);
    end
  end
`endif

  always_comb begin
    status                     = '0;
    status[ST_FULL]            = fifo_full;
    status[ST_EMPTY]           = fifo_empty;
    status[ST_BUSY]            = (state != IDLE);
    status[ST_OVF]             = overflow;
    status[ST_CNT_LSB +: 8]    = 8'(fifo_count);
  end

  // Read data has no side effects; the core samples it in the same cycle.
  always_comb begin
    data_out_o = '0;
    if (sel_o) begin
      case (addr_i[3:2])
        REG_STATUS: data_out_o = status;
`ifdef UART_TX_IRQ_EN
        REG_CTRL:   data_out_o = {31'b0, irq_en};
`endif
        default:    data_out_o = '0;
      endcase
    end
  end

endmodule
